// File: rtl/tank_ctrl_if.sv
// Bus between the tank controller and its environment: keyboard, pixel scan,
// bullet-pool fire handshake, position/facing outputs and a cooldown debug view.
interface tank_ctrl_if;
  logic [7:0] keycode;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       fire_ack;
  logic       is_tank;
  logic [9:0] tank_X;
  logic [9:0] tank_Y;
  logic [1:0] facing;
  logic       fire_req;
  logic [9:0] fire_X;
  logic [9:0] fire_Y;
  logic [1:0] fire_dir;
  logic [7:0] dbg_cooldown;

  modport master (
    input  keycode, DrawX, DrawY, fire_ack,
    output is_tank, tank_X, tank_Y, facing, fire_req, fire_X, fire_Y, fire_dir,
    output dbg_cooldown
  );

  modport slave (
    output keycode, DrawX, DrawY, fire_ack,
    input  is_tank, tank_X, tank_Y, facing, fire_req, fire_X, fire_Y, fire_dir,
    input  dbg_cooldown
  );
endinterface

// File: rtl/tank_ctrl.sv
// Player tank controller: per-frame keyboard motion with edge clamping, facing,
// cooldown-gated fire request toward the bullet pool, and per-pixel hit test.
module tank_ctrl #(
  parameter logic [9:0] X_START      = 10'd500,
  parameter logic [9:0] Y_START      = 10'd240,
  parameter logic [9:0] X_MAX        = 10'd639,
  parameter logic [9:0] Y_MAX        = 10'd479,
  parameter logic [9:0] WIDTH        = 10'd50,
  parameter logic [9:0] HEIGHT       = 10'd50,
  parameter logic [9:0] STEP         = 10'd1,
  parameter logic [7:0] COOLDOWN     = 8'd30,
  parameter logic [1:0] RESET_FACING = 2'b00,
  parameter logic [7:0] KEY_UP       = 8'h1A,
  parameter logic [7:0] KEY_DOWN     = 8'h16,
  parameter logic [7:0] KEY_LEFT     = 8'h04,
  parameter logic [7:0] KEY_RIGHT    = 8'h07,
  parameter logic [7:0] KEY_FIRE     = 8'h58
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  tank_ctrl_if.master bus
);
  localparam logic [1:0]  FACE_UP    = 2'b00;
  localparam logic [1:0]  FACE_RIGHT = 2'b01;
  localparam logic [1:0]  FACE_DOWN  = 2'b10;
  localparam logic [1:0]  FACE_LEFT  = 2'b11;
  localparam logic [10:0] X_LIM  = {1'b0, X_MAX} - {1'b0, WIDTH} + 11'd1;
  localparam logic [10:0] Y_LIM  = {1'b0, Y_MAX} - {1'b0, HEIGHT} + 11'd1;
  localparam logic [9:0]  HALF_W = WIDTH >> 1;
  localparam logic [9:0]  HALF_H = HEIGHT >> 1;

  // Fire handshake: fire_req is valid, fire_ack is ready. A shot transfers on
  // the Clk edge where both are high; until then fire_req/X/Y/dir are frozen.
  typedef enum logic {ST_IDLE, ST_PEND} fire_state_t;

  fire_state_t state_q, state_d;
  logic        frame_q, frame_d;
  logic        tick_q, tick_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  facing_q, facing_d;
  logic [9:0]  fire_x_q, fire_x_d, fire_y_q, fire_y_d;
  logic [1:0]  fire_dir_q, fire_dir_d;
  logic [7:0]  cd_q, cd_d;
  logic [10:0] x_inc, y_inc, x_end, y_end;
  logic        fire_start;

  always_comb begin
    frame_d    = frame_clk;
    tick_d     = frame_clk & ~frame_q;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    facing_d   = facing_q;
    fire_x_d   = fire_x_q;
    fire_y_d   = fire_y_q;
    fire_dir_d = fire_dir_q;
    cd_d       = cd_q;
    fire_start = 1'b0;
    x_inc      = {1'b0, x_q} + {1'b0, STEP};
    y_inc      = {1'b0, y_q} + {1'b0, STEP};

    if (tick_q) begin
      if (bus.keycode == KEY_UP) begin
        facing_d = FACE_UP;
        y_d      = (y_q < STEP) ? 10'd0 : y_q - STEP;
      end else if (bus.keycode == KEY_DOWN) begin
        facing_d = FACE_DOWN;
        y_d      = (y_inc > Y_LIM) ? Y_LIM[9:0] : y_inc[9:0];
      end else if (bus.keycode == KEY_LEFT) begin
        facing_d = FACE_LEFT;
        x_d      = (x_q < STEP) ? 10'd0 : x_q - STEP;
      end else if (bus.keycode == KEY_RIGHT) begin
        facing_d = FACE_RIGHT;
        x_d      = (x_inc > X_LIM) ? X_LIM[9:0] : x_inc[9:0];
      end
      // Cooldown gate uses the value before this tick's decrement.
      fire_start = (bus.keycode == KEY_FIRE) && (cd_q == 8'd0) && (state_q == ST_IDLE);
      if (cd_q != 8'd0) cd_d = cd_q - 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fire_start) begin
          state_d    = ST_PEND;
          fire_dir_d = facing_q;
          case (facing_q)
            FACE_UP: begin
              fire_x_d = x_q + HALF_W;
              fire_y_d = y_q;
            end
            FACE_RIGHT: begin
              fire_x_d = x_q + WIDTH - 10'd1;
              fire_y_d = y_q + HALF_H;
            end
            FACE_DOWN: begin
              fire_x_d = x_q + HALF_W;
              fire_y_d = y_q + HEIGHT - 10'd1;
            end
            default: begin
              fire_x_d = x_q;
              fire_y_d = y_q + HALF_H;
            end
          endcase
        end
      end
      ST_PEND: begin
        // Completion overrides any decrement on the same tick.
        if (bus.fire_ack) begin
          state_d = ST_IDLE;
          cd_d    = COOLDOWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= 1'b0;
      tick_q     <= 1'b0;
      x_q        <= X_START;
      y_q        <= Y_START;
      facing_q   <= RESET_FACING;
      fire_x_q   <= 10'd0;
      fire_y_q   <= 10'd0;
      fire_dir_q <= 2'b00;
      cd_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tick_q     <= tick_d;
      x_q        <= x_d;
      y_q        <= y_d;
      facing_q   <= facing_d;
      fire_x_q   <= fire_x_d;
      fire_y_q   <= fire_y_d;
      fire_dir_q <= fire_dir_d;
      cd_q       <= cd_d;
    end
  end

  always_comb begin
    x_end       = {1'b0, x_q} + {1'b0, WIDTH} - 11'd1;
    y_end       = {1'b0, y_q} + {1'b0, HEIGHT} - 11'd1;
    bus.is_tank = ({1'b0, bus.DrawX} >= {1'b0, x_q}) && ({1'b0, bus.DrawX} <= x_end) &&
                  ({1'b0, bus.DrawY} >= {1'b0, y_q}) && ({1'b0, bus.DrawY} <= y_end);
  end

  assign bus.tank_X       = x_q;
  assign bus.tank_Y       = y_q;
  assign bus.facing       = facing_q;
  assign bus.fire_req     = (state_q == ST_PEND);
  assign bus.fire_X       = fire_x_q;
  assign bus.fire_Y       = fire_y_q;
  assign bus.fire_dir     = fire_dir_q;
  assign bus.dbg_cooldown = cd_q;
endmodule
